// File: rtl/uart_tx_arbiter_if.sv
// Requester, frame-config and transmitter-side signals of uart_tx_arbiter.
// slave is the arbiter's view; master is the clients'/transmitter's view.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 cfg_pen;
   logic                 cfg_peven;
   logic                 tx_en;
   logic [7:0]           tx_din;
   logic                 tx_pen;
   logic                 tx_peven;
   logic                 tx_busy;
   logic [IDW-1:0]       grant_id;
   logic                 grant_active;
   logic                 err_timeout;

   modport slave (
      input  req_valid, req_data, req_last, cfg_pen, cfg_peven, tx_busy,
      output req_ready, tx_en, tx_din, tx_pen, tx_peven, grant_id, grant_active, err_timeout
   );

   modport master (
      output req_valid, req_data, req_last, cfg_pen, cfg_peven, tx_busy,
      input  req_ready, tx_en, tx_din, tx_pen, tx_peven, grant_id, grant_active, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams,
// locking the grant across multi-byte messages and freezing parity per frame.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [NUM_REQ-1:0] ONE = 1;

   typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       pen;
      logic       peven;
   } frame_t;

   state_t         state, state_nx;
   frame_t         frm;
   logic [IDW-1:0] sel, rr, gid, pick, idx;
   logic           pick_ok, gact, timeout_hit;
   logic [CW-1:0]  cnt;

   // Descending scan so the last hit written is the nearest one after rr.
   always_comb begin
      pick_ok = 1'b0;
      pick    = gid;
      idx     = '0;
      if (gact) begin
         pick_ok = bus.req_valid[gid];
      end else begin
         for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(rr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
               pick_ok = 1'b1;
               pick    = idx;
            end
         end
      end
   end

   assign timeout_hit = (state == WAIT_BUSY) && !bus.tx_busy &&
                        (cnt == CW'(BUSY_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ISSUE holds off while the transmitter is still busy (e.g. after a reset
   // that interrupted our own frame) so tx_en never collides with tx_busy.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (pick_ok) state_nx = ACCEPT;
         ACCEPT:    state_nx = ISSUE;
         ISSUE:     if (!bus.tx_busy) state_nx = WAIT_BUSY;
         WAIT_BUSY: begin
            if (bus.tx_busy)      state_nx = WAIT_DONE;
            else if (timeout_hit) state_nx = IDLE;
         end
         WAIT_DONE: if (!bus.tx_busy) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel  <= '0;
         rr   <= IDW'(NUM_REQ - 1);
         gid  <= '0;
         gact <= 1'b0;
         cnt  <= '0;
         frm  <= '0;
      end else begin
         case (state)
            IDLE: if (pick_ok) begin
               sel <= pick;
               gid <= pick;
            end
            ACCEPT: begin
               frm <= {bus.req_data[{sel, 3'b000} +: 8], bus.req_last[sel],
                       bus.cfg_pen, bus.cfg_peven};
               rr  <= sel;
            end
            ISSUE: cnt <= '0;
            WAIT_BUSY: if (!bus.tx_busy) begin
               cnt <= cnt + 1'b1;
               if (timeout_hit) gact <= 1'b0;
            end
            WAIT_DONE: if (!bus.tx_busy) gact <= ~frm.last;
            default: ;
         endcase
      end
   end

   assign bus.req_ready    = (state == ACCEPT) ? (ONE << sel) : '0;
   assign bus.tx_en        = (state == ISSUE) && !bus.tx_busy;
   assign bus.tx_din       = frm.data;
   assign bus.tx_pen       = frm.pen;
   assign bus.tx_peven     = frm.peven;
   assign bus.grant_id     = gid;
   assign bus.grant_active = gact;
   assign bus.err_timeout  = timeout_hit;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level arbitration model and a behavioural transmitter.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int BT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
   uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0, n_pass = 0, cyc = 0;
   logic [8:0] q [N][$];            // {last, byte} per requester
   logic [N-1:0] prev_valid = '0, acc_vec = '0, en_mask = '1;
   int v_since [N];
   // arbitration model
   int m_rr = N - 1, m_owner = 0;
   bit m_lock = 0;
   bit pend_v = 0, pend_last = 0, pend_pen = 0, pend_peven = 0;
   logic [7:0] pend_d = '0;
   // transmitter model
   int f_start = 0, f_end = 0;
   bit f_own = 0, f_last = 0, f_pen = 0, f_peven = 0;
   logic [7:0] f_d = '0;
   int exp_err = -1, drop_n = 0, tx_dmax = 0, tx_lmin = 2;
   bit rand_drop = 0, cfg_rand = 0, zero_chk = 0;
   int p_valid = 100, en_cnt = 0, n_err = 0, acc_cyc = 0, lat_ready = 0, lat_en = 0;
   logic [7:0] en_log [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
   endtask

   // Rule-level choice of the next owner, from last cycle's valid vector.
   function automatic int model_pick();
      if (m_lock) return prev_valid[m_owner] ? m_owner : N;
      for (int k = 1; k <= N; k++)
         if (prev_valid[(m_rr + k) % N]) return (m_rr + k) % N;
      return N;
   endfunction

   task automatic step();
      logic [N-1:0] rdy, vld;
      int r;
      @(negedge clk);
      cyc++;
      rdy = bus.req_ready;
      acc_vec = rdy;
      if (zero_chk) begin
         zero_chk = 0;
         chk("rst_ready", rdy, 0);
         chk("rst_tx_en", bus.tx_en, 0);
         chk("rst_tx_din", bus.tx_din, 0);
         chk("rst_tx_pen", bus.tx_pen, 0);
         chk("rst_tx_peven", bus.tx_peven, 0);
         chk("rst_grant_id", bus.grant_id, 0);
         chk("rst_grant_active", bus.grant_active, 0);
         chk("rst_err", bus.err_timeout, 0);
      end
      if (rdy != '0) begin
         r = 0;
         for (int i = N - 1; i >= 0; i--) if (rdy[i]) r = i;
         chk("ready_onehot", $countones(rdy), 1);
         chk("grant", r, model_pick());
         chk("grant_id", bus.grant_id, r);
         chk("grant_active", bus.grant_active, m_lock);
         lat_ready = cyc - v_since[r];
         acc_cyc = cyc;
         m_rr = r;
         m_owner = r;
         pend_v = 1;
         pend_d = q[r][0][7:0];
         pend_last = q[r][0][8];
         pend_pen = bus.cfg_pen;
         pend_peven = bus.cfg_peven;
      end
      if (bus.tx_en) begin
         chk("en_has_byte", pend_v, 1);
         chk("en_tx_idle", bus.tx_busy, 0);
         chk("tx_din", bus.tx_din, pend_d);
         chk("tx_pen", bus.tx_pen, pend_pen);
         chk("tx_peven", bus.tx_peven, pend_peven);
         if (f_own && f_end > 0) chk("en_gap", (cyc - f_end) >= 3, 1);
         lat_en = cyc - acc_cyc;
         en_log.push_back(bus.tx_din);
         en_cnt++;
         pend_v = 0;
         if (drop_n > 0 || (rand_drop && $urandom_range(7) == 0)) begin
            if (drop_n > 0) drop_n--;
            exp_err = cyc + BT;
         end else begin
            f_start = cyc + 1 + int'($urandom_range(tx_dmax));
            f_end = f_start + int'($urandom_range(tx_lmin, tx_lmin + 4));
            f_own = 1;
            f_d = pend_d;
            f_last = pend_last;
            f_pen = pend_pen;
            f_peven = pend_peven;
         end
      end
      if (bus.err_timeout) n_err++;
      if (bus.err_timeout || cyc == exp_err) begin
         chk("err_timeout", bus.err_timeout, cyc == exp_err);
         if (cyc == exp_err) begin
            m_lock = 0;
            exp_err = -1;
         end
      end
      if (f_own && cyc == f_end - 1) begin
         chk("hold_din", bus.tx_din, f_d);
         chk("hold_pen", bus.tx_pen, f_pen);
         chk("hold_peven", bus.tx_peven, f_peven);
      end
      if (f_own && cyc == f_end) m_lock = !f_last;
      for (int i = 0; i < N; i++)
         if (bus.req_valid[i] && !prev_valid[i]) v_since[i] = cyc;
      prev_valid = bus.req_valid;

      @(posedge clk);
      #1;
      if (rst) begin
         m_rr = N - 1;
         m_lock = 0;
         pend_v = 0;
         f_own = 0;
         exp_err = -1;
      end
      bus.tx_busy = (cyc + 1 >= f_start) && (cyc + 1 < f_end);
      vld = bus.req_valid;
      for (int i = 0; i < N; i++) begin
         if (acc_vec[i]) begin
            void'(q[i].pop_front());
            vld[i] = 1'b0;
         end
         if (!vld[i] && q[i].size() > 0 && en_mask[i] && $urandom_range(99) < p_valid) begin
            vld[i] = 1'b1;
            bus.req_data[8*i +: 8] = q[i][0][7:0];
            bus.req_last[i] = q[i][0][8];
         end
      end
      bus.req_valid = vld;
      if (cfg_rand) begin
         bus.cfg_pen = 1'($urandom);
         bus.cfg_peven = 1'($urandom);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      zero_chk = 1;
      step();
   endtask

   task automatic phase_start();
      do_reset();
      en_cnt = 0;
      n_err = 0;
      en_log.delete();
      en_mask = '1;
   endtask

   task automatic wait_en(input int n, input string tag);
      for (int k = 0; k < 2000 && en_cnt < n; k++) step();
      chk(tag, en_cnt, n);
   endtask

   task automatic wait_idle(input int budget);
      bit done = 0;
      bit empty;
      for (int k = 0; k < budget && !done; k++) begin
         step();
         empty = 1;
         for (int i = 0; i < N; i++) if (q[i].size() != 0) empty = 0;
         done = empty && !pend_v && exp_err < 0 && cyc > f_end + 3 && bus.req_valid == '0;
      end
      chk("idle_bound", done, 1);
      chk("idle_grant_active", bus.grant_active, 0);
   endtask

   initial begin
      logic [7:0] exp_rr [5];
      logic par;
      int total;
      bus.req_valid = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      bus.cfg_pen = 1'b0;
      bus.cfg_peven = 1'b0;
      bus.tx_busy = 1'b0;
      for (int i = 0; i < N; i++) v_since[i] = 0;
      repeat (2) @(posedge clk);
      #1;

      // single byte from requester 0
      phase_start();
      q[0].push_back({1'b1, 8'hA5});
      wait_en(1, "single_en");
      chk("single_lat_ready", lat_ready, 1);
      chk("single_lat_en", lat_en, 1);
      chk("single_byte", en_log[0], 8'hA5);
      wait_idle(200);

      // round robin with a refill on requester 0
      phase_start();
      exp_rr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
      q[0].push_back({1'b1, 8'h00});
      q[0].push_back({1'b1, 8'h00});
      for (int i = 1; i < N; i++) q[i].push_back({1'b1, 8'(i)});
      wait_en(5, "rr_en");
      for (int k = 0; k < 5; k++) chk("rr_order", en_log[k], exp_rr[k]);
      wait_idle(300);

      // locked three-byte message from requester 1
      phase_start();
      en_mask = 4'b0010;
      q[1].push_back({1'b0, 8'h10});
      q[1].push_back({1'b0, 8'h11});
      q[1].push_back({1'b1, 8'h12});
      q[0].push_back({1'b1, 8'h00});
      q[2].push_back({1'b1, 8'h20});
      wait_en(1, "lock_en1");
      en_mask = '1;
      wait_en(4, "lock_en4");
      chk("lock_b1", en_log[1], 8'h11);
      chk("lock_b2", en_log[2], 8'h12);
      chk("lock_next", en_log[3], 8'h20);
      wait_idle(300);

      // parity config frozen for the frame
      phase_start();
      bus.cfg_pen = 1'b1;
      bus.cfg_peven = 1'b1;
      q[3].push_back({1'b1, 8'h07});
      wait_en(1, "par_en");
      bus.cfg_pen = 1'b0;
      bus.cfg_peven = 1'b0;
      step();
      chk("par_pen", bus.tx_pen, 1);
      chk("par_peven", bus.tx_peven, 1);
      par = bus.tx_peven ? ^bus.tx_din : ~^bus.tx_din;
      chk("par_bit", par, 1);
      wait_idle(200);

      // timeout drops a locked byte and unlocks
      phase_start();
      en_mask = 4'b0010;
      q[1].push_back({1'b0, 8'h30});
      q[1].push_back({1'b0, 8'h31});
      q[1].push_back({1'b1, 8'h32});
      q[2].push_back({1'b1, 8'h40});
      wait_en(1, "to_en1");
      en_mask = '1;
      drop_n = 1;
      wait_en(4, "to_en4");
      chk("to_dropped", en_log[1], 8'h31);
      chk("to_next", en_log[2], 8'h40);
      chk("to_resume", en_log[3], 8'h32);
      chk("to_pulses", n_err, 1);
      wait_idle(300);

      // reset while locked in WAIT_DONE
      phase_start();
      tx_lmin = 6;
      en_mask = 4'b0010;
      q[1].push_back({1'b0, 8'h50});
      q[1].push_back({1'b1, 8'h51});
      wait_en(1, "rst_en1");
      en_mask = '1;
      q[0].push_back({1'b1, 8'h60});
      q[2].push_back({1'b1, 8'h61});
      q[3].push_back({1'b1, 8'h62});
      wait_en(2, "rst_en2");
      step();
      chk("pre_rst_grant_active", bus.grant_active, 1);
      do_reset();
      wait_en(3, "rst_en3");
      chk("rst_first_grant", en_log[2], 8'h60);
      wait_idle(400);
      tx_lmin = 2;

      // randomized traffic
      for (int rep = 0; rep < 3; rep++) begin
         phase_start();
         cfg_rand = 1;
         p_valid = 40;
         tx_dmax = BT - 1;
         rand_drop = 1;
         total = 0;
         for (int i = 0; i < N; i++)
            for (int m = 0; m < 3; m++) begin
               int len = int'($urandom_range(1, 3));
               for (int b = 0; b < len; b++) begin
                  q[i].push_back({b == len - 1, 8'($urandom)});
                  total++;
               end
            end
         wait_idle(5000);
         chk("rnd_bytes", en_cnt, total);
         cfg_rand = 0;
         p_valid = 100;
         tx_dmax = 0;
         rand_drop = 0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
